// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte producers, the arbiter and the shared uart_tx.
//   req / req_data : producer requests and their bytes (into arbiter)
//   ack            : per-producer accept pulse (out of arbiter)
//   tx_data/tx_send: byte and send pulse to uart_tx (out of arbiter)
//   tx_busy        : busy flag from uart_tx (into arbiter)
//   grant_id, active, timeout_err : status (out of arbiter)
// Modports: slave = the arbiter, master = everything around it.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_send;
   logic                      tx_busy;
   logic [ID_W-1:0]           grant_id;
   logic                      active;
   logic                      timeout_err;

   modport slave (
      input  req, req_data, tx_busy,
      output ack, tx_data, tx_send, grant_id, active, timeout_err
   );

   modport master (
      output req, req_data, tx_busy,
      input  ack, tx_data, tx_send, grant_id, active, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// One byte per grant: the winner's byte is driven on tx_data with a one
// cycle tx_send/ack pulse, then the FSM waits for tx_busy to rise and fall
// before granting again. If tx_busy never rises within BUSY_TIMEOUT cycles
// a one cycle timeout_err pulse is raised and the arbiter returns to idle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_tx_arbiter_if slave (req, req_data, ack, tx_data,
//                tx_send, tx_busy, grant_id, active, timeout_err)
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_arbiter_if.slave   bus
);
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_BUSY = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;

   logic [1:0]        state;
   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  cnt;

   logic              win_found;
   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   idx;
   logic [DATA_W-1:0] win_data;
   logic [ID_W-1:0]   next_ptr;

   // First set request bit searching upward from rr_ptr with wrap.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   assign win_data = bus.req_data[win_id*DATA_W +: DATA_W];
   assign next_ptr = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         cnt             <= '0;
         bus.ack         <= '0;
         bus.tx_data     <= '0;
         bus.tx_send     <= 1'b0;
         bus.grant_id    <= '0;
         bus.active      <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         // Pulse outputs default low every cycle.
         bus.tx_send     <= 1'b0;
         bus.ack         <= '0;
         bus.timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found && !bus.tx_busy) begin
                  bus.tx_data  <= win_data;
                  bus.tx_send  <= 1'b1;
                  bus.ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                  bus.grant_id <= win_id;
                  bus.active   <= 1'b1;
                  rr_ptr       <= next_ptr;
                  cnt          <= '0;
                  state        <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state <= WAIT_DONE;
               end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                  // Transmitter never acknowledged the send; give up on it.
                  bus.timeout_err <= 1'b1;
                  bus.active      <= 1'b0;
                  state           <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  bus.active <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               bus.active <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule
